fb_controller: RTL and testbench

//  Parametrised framebuffer: block-RAM pixel store with a byte-stream loader and a pipelined scanout port.
//  The loader FSM takes framed packets (header, address, length, pixels) from a byte source with a

---
 rtl/fb_controller.sv | 213 +++++++++++++++++++++
 tb/tb_fb_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_controller.sv
// fb_controller: block-RAM framebuffer with a byte-stream packet loader and a
// two-cycle pipelined scanout port.
//
// Packet format on the loader stream: HDR, ADDR_H, ADDR_L, LEN_H, LEN_L, then LEN
// pixel bytes. The low BPP bits of each pixel byte are stored, and the write
// address wraps at FB_W*FB_H.
//
// Optional feature: define FB_DOUBLE_BUFFER_EN for two banks. The loader then
// fills the back bank, and a completed packet is swapped to the front on the
// next frame_start.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_data/in_valid/in_ack  loader byte stream; in_ack pulses once per consumed byte
//   pix_x/pix_y/pix_active   scanout coordinates and visible-area qualifier
//   frame_start              vertical-blank pulse (bank swap point)
//   pixel_out                scanout pixel, 2 clk after coordinates
//   busy/done/err            loader status: not idle / packet done / packet rejected
//   bank_front               displayed bank index
module fb_controller #(
  parameter int unsigned FB_W = 200,
  parameter int unsigned FB_H = 150,
  parameter int unsigned BPP  = 6,
  parameter int unsigned XW   = 9,
  parameter int unsigned YW   = 8,
  parameter logic [7:0]  HDR  = 8'hA5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ack,
  input  logic [XW-1:0]  pix_x,
  input  logic [YW-1:0]  pix_y,
  input  logic           pix_active,
  input  logic           frame_start,
  output logic [BPP-1:0] pixel_out,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           bank_front
);

  localparam int unsigned FbN = FB_W * FB_H;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam int unsigned RamDepth = 2 * FbN;
`else
  localparam int unsigned RamDepth = FbN;
`endif
  localparam int unsigned RamAw = $clog2(RamDepth);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StAh   = 3'd1;
  localparam logic [2:0] StAl   = 3'd2;
  localparam logic [2:0] StLh   = 3'd3;
  localparam logic [2:0] StLl   = 3'd4;
  localparam logic [2:0] StData = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      len_q, len_d;
  logic             in_ack_q, in_ack_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             consume;
  logic             we;
  logic [RamAw-1:0] wr_addr;
  logic [RamAw-1:0] back_off, front_off;
  logic [RamAw-1:0] rd_addr_q, rd_addr_d;
  logic             vis_q, vis_d;
  logic [BPP-1:0]   pixel_out_q;

  logic [BPP-1:0] ram [RamDepth];

  // A byte is taken only while no ack is outstanding, so at most one per 2 cycles.
  assign consume  = in_valid & ~in_ack_q;
  assign in_ack_d = consume;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we      = 1'b0;
    if (consume) begin
      case (state_q)
        StIdle: if (in_data == HDR) state_d = StAh;
        StAh: begin
          addr_d  = {in_data, addr_q[7:0]};
          state_d = StAl;
        end
        StAl: begin
          addr_d  = {addr_q[15:8], in_data};
          state_d = StLh;
        end
        StLh: begin
          len_d   = {in_data, len_q[7:0]};
          state_d = StLl;
        end
        StLl: begin
          len_d = {len_q[15:8], in_data};
          if (32'(addr_q) >= FbN) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else if (len_d == 16'd0) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
        StData: begin
          we     = 1'b1;
          addr_d = (32'(addr_q) == FbN - 1) ? 16'd0 : addr_q + 16'd1;
          len_d  = len_q - 16'd1;
          if (len_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= 16'd0;
      len_q    <= 16'd0;
      in_ack_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      in_ack_q <= in_ack_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef FB_DOUBLE_BUFFER_EN
  logic bank_front_q, bank_front_d;
  logic swap_pending_q, swap_pending_d;

  // A done coinciding with frame_start only arms the swap for the next frame.
  always_comb begin
    bank_front_d   = bank_front_q;
    swap_pending_d = swap_pending_q;
    if (frame_start && swap_pending_q) begin
      bank_front_d   = ~bank_front_q;
      swap_pending_d = 1'b0;
    end
    if (done_q) swap_pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_front_q   <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      bank_front_q   <= bank_front_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign bank_front = bank_front_q;
  assign back_off   = bank_front_q ? '0 : RamAw'(FbN);
  assign front_off  = bank_front_q ? RamAw'(FbN) : '0;
`else
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
  assign bank_front         = 1'b0;
  assign back_off           = '0;
  assign front_off          = '0;
`endif

  assign wr_addr = RamAw'(addr_q) + back_off;

  // Scanout stage 1: linear address, forced to 0 when not visible to keep it in range.
  always_comb begin
    vis_d     = pix_active & (32'(pix_x) < FB_W) & (32'(pix_y) < FB_H);
    rd_addr_d = '0;
    if (vis_d) rd_addr_d = RamAw'(32'(pix_y) * FB_W + 32'(pix_x)) + front_off;
  end

  // Write port; the read in the scanout block sees the pre-write value (read-first).
  always_ff @(posedge clk) begin
    if (we && !rst) ram[wr_addr] <= in_data[BPP-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q   <= '0;
      vis_q       <= 1'b0;
      pixel_out_q <= '0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      vis_q       <= vis_d;
      pixel_out_q <= vis_q ? ram[rd_addr_q] : '0;
    end
  end

  assign pixel_out = pixel_out_q;
  assign in_ack    = in_ack_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fb_controller.sv
// Directed testbench for fb_controller (default parameters, BPP=6).
module tb_fb_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ack;
  logic [8:0] pix_x = 9'd0;
  logic [7:0] pix_y = 8'd0;
  logic       pix_active = 1'b0;
  logic       frame_start = 1'b0;
  logic [5:0] pixel_out;
  logic       busy, done, err, bank_front;

  int vecs = 0;
  int errs = 0;
  int ack_tot = 0;
  int done_tot = 0;
  int err_tot = 0;

  fb_controller dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ack     (in_ack),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_active (pix_active),
    .frame_start(frame_start),
    .pixel_out  (pixel_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bank_front (bank_front)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (in_ack) ack_tot++;
    if (done) done_tot++;
    if (err) err_tot++;
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_hdr(input logic [15:0] a, input logic [15:0] n);
    send_byte(8'hA5);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic read_pix(input logic [8:0] x, input logic [7:0] y, input logic act,
                          output logic [5:0] v);
    pix_x      = x;
    pix_y      = y;
    pix_active = act;
    @(posedge clk); @(posedge clk); #1;
    v          = pixel_out;
    pix_active = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (in_ack !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b expected 0", in_ack); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", done); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b expected 0", err); end
    vecs++; if (pixel_out !== 6'h00) begin errs++; $display("FAIL reset_pix: got %h expected 00", pixel_out); end
    vecs++; if (bank_front !== 1'b0) begin errs++; $display("FAIL reset_bank: got %b expected 0", bank_front); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_discard;
    int a0, d0;
    a0 = ack_tot; d0 = done_tot;
    send_byte(8'h12);
    vecs++; if (ack_tot - a0 !== 1) begin errs++; $display("FAIL discard_ack: got %0d expected 1", ack_tot - a0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL discard_busy: got %b expected 0", busy); end
    vecs++; if (done_tot - d0 !== 0) begin errs++; $display("FAIL discard_done: got %0d expected 0", done_tot - d0); end
  endtask

  task automatic test_basic;
    int a0, d0, e0;
    logic [5:0] v;
    a0 = ack_tot; d0 = done_tot; e0 = err_tot;
    send_byte(8'hA5);
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy_hdr: got %b expected 1", busy); end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    vecs++; if (ack_tot - a0 !== 8) begin errs++; $display("FAIL basic_acks: got %0d expected 8", ack_tot - a0); end
    vecs++; if (done_tot - d0 !== 1) begin errs++; $display("FAIL basic_done: got %0d expected 1", done_tot - d0); end
    vecs++; if (err_tot - e0 !== 0) begin errs++; $display("FAIL basic_err: got %0d expected 0", err_tot - e0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    read_pix(9'd0, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h11) begin errs++; $display("FAIL basic_ram0: got %h expected 11", v); end
    read_pix(9'd1, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h22) begin errs++; $display("FAIL basic_ram1: got %h expected 22", v); end
    read_pix(9'd2, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h33) begin errs++; $display("FAIL basic_ram2: got %h expected 33", v); end
  endtask

  task automatic test_wrap;
    int d0;
    logic [5:0] v;
    d0 = done_tot;
    send_hdr(16'h752F, 16'd2);
    send_byte(8'h3F); send_byte(8'h01);
    vecs++; if (done_tot - d0 !== 1) begin errs++; $display("FAIL wrap_done: got %0d expected 1", done_tot - d0); end
    read_pix(9'd199, 8'd149, 1'b1, v);
    vecs++; if (v !== 6'h3F) begin errs++; $display("FAIL wrap_last: got %h expected 3f", v); end
    read_pix(9'd0, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h01) begin errs++; $display("FAIL wrap_first: got %h expected 01", v); end
  endtask

  task automatic test_mask;
    logic [5:0] v;
    send_hdr(16'd10, 16'd1);
    send_byte(8'hC7);
    read_pix(9'd10, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h07) begin errs++; $display("FAIL mask: got %h expected 07", v); end
  endtask

  task automatic test_len_zero;
    int d0, e0;
    logic [5:0] v;
    send_hdr(16'd20, 16'd1);
    send_byte(8'h15);
    d0 = done_tot; e0 = err_tot;
    send_hdr(16'd20, 16'd0);
    vecs++; if (done_tot - d0 !== 1) begin errs++; $display("FAIL len0_done: got %0d expected 1", done_tot - d0); end
    vecs++; if (err_tot - e0 !== 0) begin errs++; $display("FAIL len0_err: got %0d expected 0", err_tot - e0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL len0_busy: got %b expected 0", busy); end
    send_byte(8'h2E);
    read_pix(9'd20, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h15) begin errs++; $display("FAIL len0_nowrite: got %h expected 15", v); end
  endtask

  task automatic test_err;
    int d0, e0;
    logic [5:0] v;
    d0 = done_tot; e0 = err_tot;
    send_hdr(16'h7530, 16'd1);
    vecs++; if (err_tot - e0 !== 1) begin errs++; $display("FAIL err_pulse: got %0d expected 1", err_tot - e0); end
    vecs++; if (done_tot - d0 !== 0) begin errs++; $display("FAIL err_done: got %0d expected 0", done_tot - d0); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL err_busy: got %b expected 0", busy); end
    send_byte(8'h3F);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL err_idle_after: got %b expected 0", busy); end
    read_pix(9'd0, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h01) begin errs++; $display("FAIL err_ram0: got %h expected 01", v); end
  endtask

  task automatic test_scanout;
    logic [5:0] v;
    send_hdr(16'd205, 16'd1);
    send_byte(8'h2A);
    send_hdr(16'd400, 16'd1);
    send_byte(8'h1B);
    pix_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pix_x = 9'd5; pix_y = 8'd1; pix_active = 1'b1;
    @(posedge clk); #1;
    vecs++; if (pixel_out !== 6'h00) begin errs++; $display("FAIL scan_lat1: got %h expected 00", pixel_out); end
    @(posedge clk); #1;
    vecs++; if (pixel_out !== 6'h2A) begin errs++; $display("FAIL scan_lat2: got %h expected 2a", pixel_out); end
    pix_active = 1'b0;
    read_pix(9'd200, 8'd1, 1'b1, v);
    vecs++; if (v !== 6'h00) begin errs++; $display("FAIL scan_x_oob: got %h expected 00", v); end
    read_pix(9'd5, 8'd1, 1'b0, v);
    vecs++; if (v !== 6'h00) begin errs++; $display("FAIL scan_inactive: got %h expected 00", v); end
    read_pix(9'd5, 8'd150, 1'b1, v);
    vecs++; if (v !== 6'h00) begin errs++; $display("FAIL scan_y_oob: got %h expected 00", v); end
    read_pix(9'd0, 8'd2, 1'b1, v);
    vecs++; if (v !== 6'h1B) begin errs++; $display("FAIL scan_row2: got %h expected 1b", v); end
  endtask

  task automatic test_rst_mid;
    int d0, e0;
    logic [5:0] v;
    send_hdr(16'd100, 16'd4);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_hdr(16'd100, 16'd4);
    send_byte(8'h0A); send_byte(8'h0B);
    d0 = done_tot; e0 = err_tot;
    // Third pixel presented on the reset cycle must not be written.
    in_data = 8'h0C; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b expected 0", busy); end
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (done_tot - d0 !== 0) begin errs++; $display("FAIL rst_done: got %0d expected 0", done_tot - d0); end
    vecs++; if (err_tot - e0 !== 0) begin errs++; $display("FAIL rst_err: got %0d expected 0", err_tot - e0); end
    d0 = done_tot;
    send_hdr(16'd300, 16'd2);
    send_byte(8'h05); send_byte(8'h06);
    vecs++; if (done_tot - d0 !== 1) begin errs++; $display("FAIL rst_next_done: got %0d expected 1", done_tot - d0); end
    read_pix(9'd100, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h0A) begin errs++; $display("FAIL rst_ram100: got %h expected 0a", v); end
    read_pix(9'd101, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h0B) begin errs++; $display("FAIL rst_ram101: got %h expected 0b", v); end
    read_pix(9'd102, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h03) begin errs++; $display("FAIL rst_ram102: got %h expected 03", v); end
    read_pix(9'd103, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h04) begin errs++; $display("FAIL rst_ram103: got %h expected 04", v); end
    read_pix(9'd100, 8'd1, 1'b1, v);
    vecs++; if (v !== 6'h05) begin errs++; $display("FAIL rst_ram300: got %h expected 05", v); end
    read_pix(9'd101, 8'd1, 1'b1, v);
    vecs++; if (v !== 6'h06) begin errs++; $display("FAIL rst_ram301: got %h expected 06", v); end
  endtask

  task automatic pulse_frame_start;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic test_double_buffer;
    logic [5:0] v;
    send_hdr(16'd5, 16'd1);
    send_byte(8'h11);
    repeat (3) @(posedge clk);
    #1;
    vecs++; if (bank_front !== 1'b0) begin errs++; $display("FAIL db_hold0: got %b expected 0", bank_front); end
    pulse_frame_start();
    vecs++; if (bank_front !== 1'b1) begin errs++; $display("FAIL db_swap1: got %b expected 1", bank_front); end
    read_pix(9'd5, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h11) begin errs++; $display("FAIL db_front1: got %h expected 11", v); end
    pulse_frame_start();
    vecs++; if (bank_front !== 1'b1) begin errs++; $display("FAIL db_noswap: got %b expected 1", bank_front); end
    send_hdr(16'd5, 16'd1);
    send_byte(8'h2B);
    @(posedge clk); #1;
    vecs++; if (bank_front !== 1'b1) begin errs++; $display("FAIL db_hold1: got %b expected 1", bank_front); end
    read_pix(9'd5, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h11) begin errs++; $display("FAIL db_old_data: got %h expected 11", v); end
    pulse_frame_start();
    vecs++; if (bank_front !== 1'b0) begin errs++; $display("FAIL db_swap0: got %b expected 0", bank_front); end
    read_pix(9'd5, 8'd0, 1'b1, v);
    vecs++; if (v !== 6'h2B) begin errs++; $display("FAIL db_new_data: got %h expected 2b", v); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_idle_discard();
`ifdef FB_DOUBLE_BUFFER_EN
    test_double_buffer();
`else
    test_basic();
    test_wrap();
    test_mask();
    test_len_zero();
    test_err();
    test_scanout();
    test_rst_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
